// File: rtl/bp_fe_pkg.sv
// ============================================================================
// Module : bp_fe_pkg
// Brief  : Front-end shared types, configuration lookups and fetch-credit constant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`define DECLARE_BP_FE_FETCH_ENTRY_S(vaddr_width_mp, instr_width_mp, br_md_width_mp) \
  typedef struct packed {                                                          \
    logic [vaddr_width_mp-1:0] pc;                                                  \
    logic [instr_width_mp-1:0] instr;                                               \
    logic [br_md_width_mp-1:0] br_metadata;                                         \
  } bp_fe_fetch_entry_s

package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg       = 2'd0,
    e_bp_unicore_cfg   = 2'd1,
    e_bp_multicore_cfg = 2'd2
  } bp_params_e;

  // PC generation may only issue while this many slots remain: the current
  // fetch plus the two already in flight through the I$ pipeline.
  localparam int bp_fe_fetch_credit_threshold_gp = 3;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_multicore_cfg: return 48;
      default:            return 39;
    endcase
  endfunction

  function automatic int bp_instr_width(input bp_params_e cfg);
    case (cfg)
      default: return 32;
    endcase
  endfunction

  function automatic int bp_br_metadata_width(input bp_params_e cfg);
    case (cfg)
      e_bp_multicore_cfg: return 40;
      default:            return 36;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_mem_1r1w.sv
// ============================================================================
// Module : bsg_mem_1r1w
// Brief  : Storage array with one synchronous write port and one asynchronous read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bsg_mem_1r1w #(
  parameter int width_p = 1,
  parameter int els_p   = 2,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  // Contents are deliberately never reset; validity is tracked by the owner.
  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

`default_nettype wire

// File: rtl/bp_fe_fetch_buffer.sv
// ============================================================================
// Module : bp_fe_fetch_buffer
// Brief  : Credit-managed circular FIFO between fetch and the backend.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bp_fe_fetch_buffer
  import bp_fe_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int els_p = 8,
  localparam int vaddr_width_p               = bp_vaddr_width(bp_params_p),
  localparam int instr_width_p               = bp_instr_width(bp_params_p),
  localparam int branch_metadata_fwd_width_p = bp_br_metadata_width(bp_params_p),
  localparam int ptr_width_lp                = $clog2(els_p),
  localparam int cnt_width_lp                = ptr_width_lp + 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,

  input  logic                                   fetch_v_i,
  input  logic [vaddr_width_p-1:0]               fetch_pc_i,
  input  logic [instr_width_p-1:0]               fetch_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata_i,
  output logic                                   fetch_credit_o,

  input  logic                                   clear_i,

  output logic                                   fe_v_o,
  output logic [vaddr_width_p-1:0]               fe_pc_o,
  output logic [instr_width_p-1:0]               fe_instr_o,
  output logic [branch_metadata_fwd_width_p-1:0] fe_br_metadata_o,
  input  logic                                   fe_yumi_i,

  output logic [cnt_width_lp-1:0]                count_o
);

  `DECLARE_BP_FE_FETCH_ENTRY_S(vaddr_width_p, instr_width_p, branch_metadata_fwd_width_p);

  localparam logic [cnt_width_lp-1:0] full_cnt_lp   = cnt_width_lp'(els_p);
  localparam logic [cnt_width_lp-1:0] credit_max_lp =
    cnt_width_lp'(els_p - bp_fe_fetch_credit_threshold_gp);

  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0] count_q,  count_d;

  logic enq_v, deq_v, empty, full;
  bp_fe_fetch_entry_s wr_entry, rd_entry;

  assign empty = (count_q == '0);
  assign full  = (count_q == full_cnt_lp);

  // Illegal requests (enqueue while full, dequeue while empty) are simply dropped.
  assign enq_v = fetch_v_i & ~clear_i & ~full;
  assign deq_v = fe_yumi_i & ~clear_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_v) begin
        wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
      end
      if (deq_v) begin
        rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
      end
      if (enq_v && !deq_v) begin
        count_d = count_q + cnt_width_lp'(1);
      end else if (deq_v && !enq_v) begin
        count_d = count_q - cnt_width_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry = '{pc: fetch_pc_i, instr: fetch_instr_i, br_metadata: fetch_br_metadata_i};

  bsg_mem_1r1w #(
    .width_p ($bits(bp_fe_fetch_entry_s)),
    .els_p   (els_p)
  ) mem (
    .w_clk_i  (clk_i),
    .w_v_i    (enq_v),
    .w_addr_i (wr_ptr_q),
    .w_data_i (wr_entry),
    .r_addr_i (rd_ptr_q),
    .r_data_o (rd_entry)
  );

  assign fe_v_o           = ~empty;
  assign fe_pc_o          = rd_entry.pc;
  assign fe_instr_o       = rd_entry.instr;
  assign fe_br_metadata_o = rd_entry.br_metadata;
  assign count_o          = count_q;
  assign fetch_credit_o   = (count_q <= credit_max_lp);

endmodule

`default_nettype wire

// File: tb/tb_bp_fe_fetch_buffer.sv
// ============================================================================
// Module : tb_bp_fe_fetch_buffer
// Brief  : Queue-model checked bench for the fetch buffer: directed corners then random traffic.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bp_fe_fetch_buffer;
  import bp_fe_pkg::*;

  localparam int ELS = 8;
  localparam int VW  = bp_vaddr_width(e_bp_inv_cfg);
  localparam int IW  = bp_instr_width(e_bp_inv_cfg);
  localparam int MW  = bp_br_metadata_width(e_bp_inv_cfg);
  localparam int CW  = $clog2(ELS) + 1;

  typedef struct packed {
    logic [VW-1:0] pc;
    logic [IW-1:0] instr;
    logic [MW-1:0] md;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_v = 1'b0;
  logic [VW-1:0] fetch_pc = '0;
  logic [IW-1:0] fetch_instr = '0;
  logic [MW-1:0] fetch_md = '0;
  logic          clear = 1'b0;
  logic          yumi = 1'b0;
  logic          credit, fe_v;
  logic [VW-1:0] fe_pc;
  logic [IW-1:0] fe_instr;
  logic [MW-1:0] fe_md;
  logic [CW-1:0] count;

  int total = 0;
  int bad = 0;
  int illegal_cnt = 0;
  bit check_en = 1'b0;
  ent_t mq[$];

  always #5 clk = ~clk;

  bp_fe_fetch_buffer #(.bp_params_p(e_bp_inv_cfg), .els_p(ELS)) dut (
    .clk_i               (clk),
    .reset_n_i           (rst_n),
    .fetch_v_i           (fetch_v),
    .fetch_pc_i          (fetch_pc),
    .fetch_instr_i       (fetch_instr),
    .fetch_br_metadata_i (fetch_md),
    .fetch_credit_o      (credit),
    .clear_i             (clear),
    .fe_v_o              (fe_v),
    .fe_pc_o             (fe_pc),
    .fe_instr_o          (fe_instr),
    .fe_br_metadata_o    (fe_md),
    .fe_yumi_i           (yumi),
    .count_o             (count)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: a plain queue; the buffer is just FIFO order with a clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (clear) begin
      mq.delete();
    end else begin
      automatic bit was_full  = (mq.size() == ELS);
      automatic bit was_empty = (mq.size() == 0);
      if (yumi && was_empty) begin
        illegal_cnt <= illegal_cnt + 1;
        $display("illegal stimulus flagged: yumi while empty at %0t", $time);
      end
      if (fetch_v && was_full) begin
        illegal_cnt <= illegal_cnt + 1;
        $display("illegal stimulus flagged: enqueue while full at %0t", $time);
      end
      if (yumi && !was_empty) void'(mq.pop_front());
      if (fetch_v && !was_full) mq.push_back('{pc: fetch_pc, instr: fetch_instr, md: fetch_md});
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_count", 64'(count), 64'(mq.size()));
      chk("model_v", 64'(fe_v), 64'(mq.size() != 0));
      chk("model_credit", 64'(credit), 64'((ELS - mq.size()) >= 3));
      if (mq.size() != 0) begin
        chk("model_pc", 64'(fe_pc), 64'(mq[0].pc));
        chk("model_instr", 64'(fe_instr), 64'(mq[0].instr));
        chk("model_md", 64'(fe_md), 64'(mq[0].md));
      end
    end
  end

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc    = VW'(pc);
    e.instr = pc ^ 32'h1357_9BDF;
    e.md    = MW'({pc, 4'hA});
    return e;
  endfunction

  // Inputs are applied for exactly one rising edge; returns at the next falling edge.
  task automatic drive(input logic v, input ent_t e, input logic y, input logic c);
    fetch_v     = v;
    fetch_pc    = e.pc;
    fetch_instr = e.instr;
    fetch_md    = e.md;
    yumi        = y;
    clear       = c;
    @(negedge clk);
    fetch_v = 1'b0;
    yumi    = 1'b0;
    clear   = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_v", 64'(fe_v), 64'd0);
    chk("rst_credit", 64'(credit), 64'd1);
    rst_n = 1'b1;

    // Fill with consecutive PCs, credit drops once only two slots remain.
    for (int k = 0; k < ELS; k++) begin
      drive(1'b1, mk(32'h8000_0000 + 32'(4 * k)), 1'b0, 1'b0);
      chk("fill_count", 64'(count), 64'(k + 1));
      chk("fill_credit", 64'(credit), 64'((k + 1) <= 5));
      if (k < 3) chk("fill_head", 64'(fe_pc), 64'h8000_0000);
    end

    for (int k = 0; k < ELS; k++) begin
      chk("drain_pc", 64'(fe_pc), 64'h8000_0000 + 64'(4 * k));
      drive(1'b0, mk(32'h0), 1'b1, 1'b0);
    end
    chk("drain_v", 64'(fe_v), 64'd0);
    chk("drain_count", 64'(count), 64'd0);

    for (int k = 0; k < 5; k++) drive(1'b1, mk(32'h9000_0000 + 32'(4 * k)), 1'b0, 1'b0);
    chk("five_count", 64'(count), 64'd5);
    drive(1'b1, mk(32'h9000_0014), 1'b1, 1'b0);
    chk("simul_count", 64'(count), 64'd5);
    chk("simul_head", 64'(fe_pc), 64'h9000_0004);

    drive(1'b0, mk(32'h0), 1'b1, 1'b0);
    chk("four_count", 64'(count), 64'd4);
    drive(1'b1, mk(32'h9000_0018), 1'b1, 1'b1);
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_v", 64'(fe_v), 64'd0);
    drive(1'b0, mk(32'h0), 1'b0, 1'b0);
    chk("clear_absent", 64'(count), 64'd0);

    for (int k = 0; k < 6; k++) drive(1'b1, mk(32'hA000_0000 + 32'(4 * k)), 1'b0, 1'b0);
    chk("six_count", 64'(count), 64'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_v", 64'(fe_v), 64'd0);
    chk("async_credit", 64'(credit), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, mk(32'hB000_0000), 1'b0, 1'b0);
    chk("post_rst_count", 64'(count), 64'd1);
    chk("post_rst_pc", 64'(fe_pc), 64'hB000_0000);

    drive(1'b0, mk(32'h0), 1'b0, 1'b1);
    drive(1'b0, mk(32'h0), 1'b1, 1'b0);
    chk("yumi_empty_count", 64'(count), 64'd0);
    for (int k = 0; k < ELS; k++) drive(1'b1, mk(32'hC000_0000 + 32'(4 * k)), 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd8);
    drive(1'b1, mk(32'hDEAD_0000), 1'b0, 1'b0);
    chk("enq_full_count", 64'(count), 64'd8);
    chk("enq_full_head", 64'(fe_pc), 64'hC000_0000);
    chk("illegal_flagged", 64'(illegal_cnt), 64'd2);

    drive(1'b0, mk(32'h0), 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      automatic ent_t e;
      automatic logic v, y, c;
      e.pc    = VW'({$urandom, $urandom});
      e.instr = IW'($urandom);
      e.md    = MW'({$urandom, $urandom});
      v = (mq.size() < ELS) && ($urandom_range(3, 0) != 0);
      y = (mq.size() != 0) && ($urandom_range(2, 0) != 0);
      c = ($urandom_range(31, 0) == 0);
      drive(v, e, y, c);
    end
    chk("illegal_final", 64'(illegal_cnt), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bp_fe_fetch_buffer.md
BP_FE_FETCH_BUFFER -- requirements
Module: bp_fe_fetch_buffer

Interface
REQ-001 Parameter bp_params_p, default e_bp_inv_cfg, selects the processor configuration (vaddr_width_p, instr_width_p, branch_metadata_fwd_width_p).
REQ-002 Parameter els_p, default 8, is the entry count; SHALL be a power of two and at least 4.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n_i  input  1  asynchronous active-low reset.
REQ-006 fetch_v_i  input  1  fetch packet valid from PC generation.
REQ-007 fetch_pc_i  input  vaddr_width_p  PC of the fetched instruction.
REQ-008 fetch_instr_i  input  instr_width_p  fetched instruction.
REQ-009 fetch_br_metadata_i  input  branch_metadata_fwd_width_p  prediction metadata.
REQ-010 fetch_credit_o  output  1  upstream may issue a new next-PC this cycle.
REQ-011 clear_i  input  1  flush on redirect.
REQ-012 fe_v_o  output  1  head entry valid to backend.
REQ-013 fe_pc_o / fe_instr_o / fe_br_metadata_o  output  widths as REQ-007..009  head entry fields.
REQ-014 fe_yumi_i  input  1  backend consumes head entry this cycle.
REQ-015 count_o  output  $clog2(els_p)+1  current occupancy.

Function
REQ-016 Storage: circular FIFO with read pointer, write pointer (each $clog2(els_p) bits, natural wrap from els_p-1 to 0), and occupancy counter.
REQ-017 Enqueue: fetch_v_i & ~clear_i writes {pc, instr, metadata} at the write pointer; write pointer +1; entry visible on fe_*_o the next cycle at the earliest (no bypass, 1-cycle latency).
REQ-018 Dequeue: fe_yumi_i & fe_v_o & ~clear_i advances the read pointer by 1.
REQ-019 count_o next = count + enq - deq; simultaneous enqueue and dequeue leaves count unchanged and both pointers advance.
REQ-020 fe_v_o = (count_o != 0); fe_*_o carry the read-pointer entry and are don't-care while fe_v_o is low.
REQ-021 fetch_credit_o = (els_p - count_o) >= 3, which covers the two fetches in flight in the I$ pipeline plus the current one; it is purely registered-state driven and SHALL NOT depend combinationally on any input.
REQ-022 Full (count_o == els_p): fetch_v_i is illegal; the bench SHALL flag it, and the RTL SHALL drop the write and leave all state unchanged.
REQ-023 Empty: fe_yumi_i is illegal; the RTL SHALL ignore it and leave state unchanged.
REQ-024 clear_i has priority: both pointers and count go to 0 next cycle, and any same-cycle fetch_v_i and fe_yumi_i are discarded.
REQ-025 Storage contents are not cleared by clear_i or reset; only pointers and count are.

Reset
REQ-026 While reset_n_i is low: pointers = 0, count_o = 0, fe_v_o = 0, fetch_credit_o = 1 (els_p >= 4).
REQ-027 Reset asserted mid-operation takes effect immediately (asynchronously) and discards all entries; the first enqueue is accepted on the first rising edge after deassertion.

Structure
REQ-028 The entry struct bp_fe_fetch_entry_s {pc, instr, br_metadata} and its declare macro belong in bp_fe_pkg.
REQ-029 The credit threshold (3) SHALL be a named constant in bp_fe_pkg, shared with PC generation.
REQ-030 Storage SHALL be one bsg_mem_1r1w instance (width $bits(bp_fe_fetch_entry_s), els_p); pointers and counter live in this module.

Verification
REQ-031 Reset, then enqueue pc 0x80000000/0x80000004/0x80000008 on consecutive cycles with no yumi -> count_o 1,2,3, fe_pc_o = 0x80000000, fetch_credit_o high until count_o = 6.
REQ-032 Fill to 8 entries, then hold fe_yumi_i high for 8 cycles -> PCs emerge in order, pointers wrap, fe_v_o drops on the cycle after the 8th yumi.
REQ-033 With count_o = 5, apply enqueue and yumi in the same cycle -> count_o stays 5 and the head advances to the next PC.
REQ-034 With count_o = 4, assert clear_i together with fetch_v_i and fe_yumi_i -> next cycle count_o = 0, fe_v_o = 0, and the new packet is absent.
REQ-035 Drop reset_n_i low between clock edges with count_o = 6 -> fe_v_o = 0 and count_o = 0 before the next edge; enqueue after release is at index 0.
REQ-036 Illegal stimulus: yumi while empty, and enqueue while full -> state unchanged and the bench flags an error.
